// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR command sequencer: command encodings,
// sequencer states and mode-register field helpers.
package ddr_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        CMD_LMR   = 3'b000,
        CMD_AR    = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_NOP   = 3'b111
    } cmd_e;

    typedef enum logic [3:0] {
        ST_WAIT     = 4'd0,
        ST_INIT_NOP = 4'd1,
        ST_INIT_PRE = 4'd2,
        ST_EMR      = 4'd3,
        ST_MR       = 4'd4,
        ST_PRE2     = 4'd5,
        ST_INIT_AR  = 4'd6,
        ST_MR2      = 4'd7,
        ST_IDLE     = 4'd8,
        ST_ACT      = 4'd9,
        ST_RW       = 4'd10,
        ST_RECOV    = 4'd11,
        ST_REF      = 4'd12
    } state_e;

    localparam int          INIT_NOP_CYC = 5;
    localparam logic [1:0]  EMR_BA       = 2'b01;
    localparam logic [12:0] EMR_A        = 13'h0000;
    localparam logic [1:0]  MR_BA        = 2'b00;
    localparam logic [12:0] A10_ALL      = 13'h0400;

    function automatic logic [12:0] mr_value(input logic [2:0] cas, input logic [2:0] bl);
        return {4'b0000, 1'b0, 1'b0, cas, 1'b0, bl};
    endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Periodic refresh timer with a single sticky pending flag; present only
// when DDR_AUTO_REFRESH_EN is defined.
`ifdef DDR_AUTO_REFRESH_EN
module ddr_refresh_timer
    import ddr_pkg::*;
#(
    parameter int unsigned TREFI = 1040
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic ref_due
);

    logic [CNT_W-1:0] cnt_r;
    logic             pending_r;
    logic             expire_s;

    assign expire_s = enable && (cnt_r <= CNT_W'(1));
    // Due as soon as the interval expires so a same-cycle request loses.
    assign ref_due  = pending_r | expire_s;

    // Interval count with reload, and pending flag collapsing repeated expiries.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= CNT_W'(TREFI);
            pending_r <= 1'b0;
        end else begin
            if (expire_s) begin
                cnt_r <= CNT_W'(TREFI);
            end else if (enable) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (clear) begin
                pending_r <= 1'b0;
            end else if (expire_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

endmodule
`endif

// File: rtl/ddr_cmd_sequencer.sv
// DDR SDRAM init + single-access command sequencer with registered command pins.
// Optional periodic auto-refresh is enabled by defining DDR_AUTO_REFRESH_EN.
module ddr_cmd_sequencer
    import ddr_pkg::*;
#(
    parameter int unsigned INIT_WAIT_CYC = 26600,
    parameter int unsigned NUM_REFRESH   = 2,
    parameter int unsigned TRP           = 3,
    parameter int unsigned TMRD          = 2,
    parameter int unsigned TRFC          = 11,
    parameter int unsigned TRCD          = 3,
    parameter int unsigned TRECOV        = 6,
    parameter int unsigned TREFI         = 1040,
    parameter logic [2:0]  CAS_CODE      = 3'b010,
    parameter logic [2:0]  BL_CODE       = 3'b001
) (
    input  logic        clk133,
    input  logic        rst,
    output logic [12:0] sd_A,
    output logic [1:0]  sd_BA,
    output logic        sd_RAS,
    output logic        sd_CAS,
    output logic        sd_WE,
    output logic        sd_CKE,
    output logic        sd_CS,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_bank,
    input  logic [12:0] req_row,
    input  logic [9:0]  req_col,
    output logic        req_ready,
    output logic        init_done
);

    localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(INIT_WAIT_CYC);
    localparam logic [CNT_W-1:0] LD_INOP  = CNT_W'(INIT_NOP_CYC);
    localparam logic [CNT_W-1:0] LD_TRP   = CNT_W'(TRP);
    localparam logic [CNT_W-1:0] LD_TMRD  = CNT_W'(TMRD);
    localparam logic [CNT_W-1:0] LD_TRFC  = CNT_W'(TRFC);
    localparam logic [CNT_W-1:0] LD_TRCD  = CNT_W'(TRCD);
    localparam logic [CNT_W-1:0] LD_RECOV = CNT_W'(TRECOV);
    localparam logic [CNT_W-1:0] LD_ONE   = CNT_W'(1);
    localparam logic [12:0]      MR_A     = mr_value(CAS_CODE, BL_CODE);

    state_e           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       ar_cnt_r, ar_cnt_s;
    cmd_e             cmd_r, cmd_s;
    logic [12:0]      a_r, a_s;
    logic [1:0]       ba_r, ba_s;
    logic             cke_r, cke_s;
    logic             init_done_r, init_done_s;
    logic             req_write_r, req_write_s;
    logic [1:0]       req_bank_r, req_bank_s;
    logic [9:0]       req_col_r, req_col_s;
    logic             ref_pending_s, ref_clr_s, req_ready_s, last_s;

`ifdef DDR_AUTO_REFRESH_EN
    ddr_refresh_timer #(.TREFI(TREFI)) u_refresh_timer (
        .clk     (clk133),
        .rst     (rst),
        .enable  (init_done_r),
        .clear   (ref_clr_s),
        .ref_due (ref_pending_s)
    );
`else
    logic unused_s;
    assign ref_pending_s = 1'b0;
    assign unused_s      = ref_clr_s | (TREFI == 32'd0);
`endif

    // The counter holds the cycles remaining in the current state, this one included.
    assign last_s      = (cnt_r <= LD_ONE);
    assign req_ready_s = (state_r == ST_IDLE) && !ref_pending_s && init_done_r;

    // Next state plus the command to drive on the following cycle.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r - LD_ONE;
        ar_cnt_s    = ar_cnt_r;
        cmd_s       = CMD_NOP;
        a_s         = 13'h0000;
        ba_s        = 2'b00;
        cke_s       = 1'b1;
        init_done_s = init_done_r;
        req_write_s = req_write_r;
        req_bank_s  = req_bank_r;
        req_col_s   = req_col_r;
        ref_clr_s   = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (last_s) begin
                    state_s = ST_INIT_NOP; cnt_s = LD_INOP;
                end else begin
                    cke_s = 1'b0;
                end
            end
            ST_INIT_NOP: begin
                if (last_s) begin
                    state_s = ST_INIT_PRE; cnt_s = LD_TRP; cmd_s = CMD_PRE; a_s = A10_ALL;
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            ST_INIT_PRE: begin
                if (last_s) begin
                    state_s = ST_EMR; cnt_s = LD_TMRD; cmd_s = CMD_LMR; ba_s = EMR_BA; a_s = EMR_A;
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            ST_EMR: begin
                if (last_s) begin
                    state_s = ST_MR; cnt_s = LD_TMRD; cmd_s = CMD_LMR; ba_s = MR_BA; a_s = MR_A;
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            ST_MR: begin
                if (last_s) begin
                    state_s = ST_PRE2; cnt_s = LD_TRP; cmd_s = CMD_PRE; a_s = A10_ALL;
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            ST_PRE2: begin
                if (last_s) begin
                    state_s = ST_INIT_AR; cnt_s = LD_TRFC; cmd_s = CMD_AR; ar_cnt_s = 4'(NUM_REFRESH);
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            ST_INIT_AR: begin
                if (last_s && (ar_cnt_r > 4'd1)) begin
                    cnt_s = LD_TRFC; cmd_s = CMD_AR; ar_cnt_s = ar_cnt_r - 4'd1;
                end else if (last_s) begin
                    state_s = ST_MR2; cnt_s = LD_ONE; cmd_s = CMD_LMR; ba_s = MR_BA; a_s = MR_A;
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            ST_MR2: begin
                state_s = ST_IDLE; cnt_s = LD_ONE; init_done_s = 1'b1;
            end
            ST_IDLE: begin
                cnt_s = LD_ONE;
                if (ref_pending_s) begin
                    state_s = ST_REF; cnt_s = LD_TRFC; cmd_s = CMD_AR; ref_clr_s = 1'b1;
                end else if (req_valid && req_ready_s) begin
                    state_s     = ST_ACT; cnt_s = LD_TRCD; cmd_s = CMD_ACT;
                    ba_s        = req_bank; a_s = req_row;
                    req_write_s = req_write; req_bank_s = req_bank; req_col_s = req_col;
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            ST_ACT: begin
                if (last_s) begin
                    state_s = ST_RW; cnt_s = LD_ONE;
                    cmd_s   = req_write_r ? CMD_WRITE : CMD_READ;
                    ba_s    = req_bank_r; a_s = {2'b00, 1'b1, req_col_r};
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            ST_RW: begin
                state_s = ST_RECOV; cnt_s = LD_RECOV;
            end
            ST_RECOV, ST_REF: begin
                if (last_s) begin
                    state_s = ST_IDLE; cnt_s = LD_ONE;
                end else begin
                    cmd_s = CMD_NOP;
                end
            end
            default: begin
                state_s = ST_WAIT; cnt_s = LD_WAIT; cke_s = 1'b0; init_done_s = 1'b0;
            end
        endcase
    end

    // State, timing counter and registered command pins.
    always_ff @(posedge clk133) begin
        if (rst) begin
            state_r     <= ST_WAIT;
            cnt_r       <= LD_WAIT;
            ar_cnt_r    <= 4'd0;
            cmd_r       <= CMD_NOP;
            a_r         <= 13'h0000;
            ba_r        <= 2'b00;
            cke_r       <= 1'b0;
            init_done_r <= 1'b0;
            req_write_r <= 1'b0;
            req_bank_r  <= 2'b00;
            req_col_r   <= 10'h000;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ar_cnt_r    <= ar_cnt_s;
            cmd_r       <= cmd_s;
            a_r         <= a_s;
            ba_r        <= ba_s;
            cke_r       <= cke_s;
            init_done_r <= init_done_s;
            req_write_r <= req_write_s;
            req_bank_r  <= req_bank_s;
            req_col_r   <= req_col_s;
        end
    end

    assign sd_A      = a_r;
    assign sd_BA     = ba_r;
    assign sd_RAS    = cmd_r[2];
    assign sd_CAS    = cmd_r[1];
    assign sd_WE     = cmd_r[0];
    assign sd_CKE    = cke_r;
    assign sd_CS     = ~cke_r;
    assign req_ready = req_ready_s;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed, table-driven bench for ddr_cmd_sequencer (short power-up wait).
module tb_ddr_cmd_sequencer;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010, C_AR  = 3'b001, C_LMR = 3'b000;

    logic        clk133 = 1'b0;
    logic        rst;
    logic [12:0] sd_A;
    logic [1:0]  sd_BA;
    logic        sd_RAS, sd_CAS, sd_WE, sd_CKE, sd_CS;
    logic        req_valid, req_write;
    logic [1:0]  req_bank;
    logic [12:0] req_row;
    logic [9:0]  req_col;
    logic        req_ready, init_done;

    always #5 clk133 = ~clk133;

    ddr_cmd_sequencer #(.INIT_WAIT_CYC(10), .TREFI(50)) dut (
        .clk133(clk133), .rst(rst),
        .sd_A(sd_A), .sd_BA(sd_BA), .sd_RAS(sd_RAS), .sd_CAS(sd_CAS), .sd_WE(sd_WE),
        .sd_CKE(sd_CKE), .sd_CS(sd_CS),
        .req_valid(req_valid), .req_write(req_write), .req_bank(req_bank),
        .req_row(req_row), .req_col(req_col),
        .req_ready(req_ready), .init_done(init_done)
    );

    typedef struct {
        int          n;
        logic        valid;
        logic        write;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic        cke;
        logic        cs;
        logic        rdy;
        logic        done;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input int n, input logic v, input logic w, input logic [1:0] bk,
                       input logic [12:0] rw, input logic [9:0] cl, input logic [2:0] cmd,
                       input logic [1:0] ba, input logic [12:0] a, input logic cke,
                       input logic cs, input logic rdy, input logic done);
        vec_t e;
        e.n = n; e.valid = v; e.write = w; e.bank = bk; e.row = rw; e.col = cl;
        e.cmd = cmd; e.ba = ba; e.a = a; e.cke = cke; e.cs = cs; e.rdy = rdy; e.done = done;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [2:0] cmd, input logic [1:0] ba,
                         input logic [12:0] a, input logic cke, input logic cs,
                         input logic rdy, input logic done);
        logic [2:0] got;
        got = {sd_RAS, sd_CAS, sd_WE};
        n_cmp++;
        if ({got, sd_BA, sd_A, sd_CKE, sd_CS, req_ready, init_done} !==
            {cmd, ba, a, cke, cs, rdy, done}) begin
            n_bad++;
            $display("FAIL %s: got cmd=%b ba=%0d a=%h cke=%b cs=%b rdy=%b done=%b, want cmd=%b ba=%0d a=%h cke=%b cs=%b rdy=%b done=%b",
                     name, got, sd_BA, sd_A, sd_CKE, sd_CS, req_ready, init_done,
                     cmd, ba, a, cke, cs, rdy, done);
        end
    endtask

    task automatic step();
        @(posedge clk133);
        @(negedge clk133);
    endtask

    // Each record covers n consecutive cycles: inputs driven and outputs expected.
    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                req_valid = vecs[i].valid; req_write = vecs[i].write; req_bank = vecs[i].bank;
                req_row   = vecs[i].row;   req_col   = vecs[i].col;
                check($sformatf("vec%0d.%0d", i, k), vecs[i].cmd, vecs[i].ba, vecs[i].a,
                      vecs[i].cke, vecs[i].cs, vecs[i].rdy, vecs[i].done);
                step();
            end
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_bank = 2'd0; req_row = 13'h0000; req_col = 10'h000;

        // Init with a request held high throughout; it must be ignored.
        add(10, 1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add(5,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_PRE, 2'd0, 13'h0400, 1'b1, 1'b0, 1'b0, 1'b0);
        add(2,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_LMR, 2'd1, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_LMR, 2'd0, 13'h0021, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_PRE, 2'd0, 13'h0400, 1'b1, 1'b0, 1'b0, 1'b0);
        add(2,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_AR,  2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(10, 1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_AR,  2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(10, 1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1,  1'b1, 1'b1, 2'd3, 13'h0FFF, 10'h3FF, C_LMR, 2'd0, 13'h0021, 1'b1, 1'b0, 1'b0, 1'b0);
        // Write bank 2 row 1ABC col 155; inputs scrambled after accept.
        add(1,  1'b1, 1'b1, 2'd2, 13'h1ABC, 10'h155, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1,  1'b0, 1'b0, 2'd1, 13'h0000, 10'h000, C_ACT, 2'd2, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1);
        add(2,  1'b0, 1'b0, 2'd1, 13'h0000, 10'h000, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1,  1'b0, 1'b0, 2'd1, 13'h0000, 10'h000, C_WR,  2'd2, 13'h0555, 1'b1, 1'b0, 1'b0, 1'b1);
        add(6,  1'b0, 1'b0, 2'd1, 13'h0000, 10'h000, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        // Read bank 1 row 0123 col 2AA; valid stays high with other fields.
        add(1,  1'b1, 1'b0, 2'd1, 13'h0123, 10'h2AA, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1,  1'b1, 1'b1, 2'd3, 13'h1555, 10'h3FF, C_ACT, 2'd1, 13'h0123, 1'b1, 1'b0, 1'b0, 1'b1);
        add(2,  1'b1, 1'b1, 2'd3, 13'h1555, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1,  1'b1, 1'b1, 2'd3, 13'h1555, 10'h3FF, C_RD,  2'd1, 13'h06AA, 1'b1, 1'b0, 1'b0, 1'b1);
        add(6,  1'b1, 1'b1, 2'd3, 13'h1555, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        // Back-to-back write with extreme field values.
        add(1,  1'b1, 1'b1, 2'd0, 13'h1FFF, 10'h000, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1,  1'b0, 1'b0, 2'd3, 13'h0000, 10'h3FF, C_ACT, 2'd0, 13'h1FFF, 1'b1, 1'b0, 1'b0, 1'b1);
        add(2,  1'b0, 1'b0, 2'd3, 13'h0000, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1,  1'b0, 1'b0, 2'd3, 13'h0000, 10'h3FF, C_WR,  2'd0, 13'h0400, 1'b1, 1'b0, 1'b0, 1'b1);
        add(6,  1'b0, 1'b0, 2'd3, 13'h0000, 10'h3FF, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        add(3,  1'b0, 1'b0, 2'd0, 13'h0000, 10'h000, C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

        repeat (3) @(posedge clk133);
        @(negedge clk133);
        check("reset", C_NOP, 2'd0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        run(0, vecs.size() - 1);

        // Reset pulsed during write recovery aborts and restarts the whole init.
        req_valid = 1'b1; req_write = 1'b1; req_bank = 2'd3; req_row = 13'h0A0A; req_col = 10'h0F0;
        check("abort_idle", C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        req_valid = 1'b0;
        check("abort_act", C_ACT, 2'd3, 13'h0A0A, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) step();
        check("abort_wr", C_WR, 2'd3, 13'h04F0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("abort_rst", C_NOP, 2'd0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        run(0, 14);
        req_valid = 1'b0;
        check("reinit_idle", C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

`ifdef DDR_AUTO_REFRESH_EN
        // First AR lands TREFI cycles after init_done rises.
        k = 0;
        while (k < 200 && {sd_RAS, sd_CAS, sd_WE} !== C_AR) begin
            step();
            k++;
        end
        n_cmp++;
        if (k != 50) begin
            n_bad++;
            $display("FAIL ref_first: AR after %0d cycles, want 50", k);
        end
        // Next expiry meets a request in IDLE: refresh wins, ACT follows AR,
        // TRFC-1 NOPs and one accept cycle.
        repeat (49) step();
        req_valid = 1'b1; req_write = 1'b0; req_bank = 2'd1; req_row = 13'h0111; req_col = 10'h011;
        check("ref_vs_req", C_NOP, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check("ref_ar", C_AR, 2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (12) step();
        req_valid = 1'b0;
        check("ref_then_act", C_ACT, 2'd1, 13'h0111, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        k = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_sequencer.md
DDR_CMD_SEQUENCER -- requirements
Module: ddr_cmd_sequencer

Interface
REQ-001 Parameter INIT_WAIT_CYC, default 26600, sets the power-up wait with CKE low (200 us at 133 MHz).
REQ-002 Parameter NUM_REFRESH, default 2, is the number of auto-refreshes in the init sequence (range 1..15).
REQ-003 Parameters TRP=3, TMRD=2, TRFC=11, TRCD=3 and TRECOV=6 are timing intervals in clocks (range 2..31).
REQ-004 Parameter TREFI, default 1040, is the periodic refresh interval in clocks.
REQ-005 Parameters CAS_CODE=3'b010 and BL_CODE=3'b001 are the mode-register CAS-latency and burst-length fields.
REQ-006 Port clk133, input, width 1, is the single clock; all logic is rising-edge.
REQ-007 Port rst, input, width 1, is the synchronous active-high reset.
REQ-008 Ports sd_A (output, 13), sd_BA (output, 2), sd_RAS, sd_CAS, sd_WE, sd_CKE and sd_CS (outputs, 1 each) are the registered DDR command outputs.
REQ-009 Ports req_valid (input, 1), req_write (input, 1), req_bank (input, 2), req_row (input, 13) and req_col (input, 10) form the user request.
REQ-010 Port req_ready, output, width 1, is the request accept strobe; a request transfers when req_valid and req_ready are both high.
REQ-011 Port init_done, output, width 1, is high once initialisation completes, then stays high until rst.

Function
REQ-012 The command on {RAS,CAS,WE} SHALL be one of: NOP 111, ACT 011, READ 101, WRITE 100, PRE 010, AR 001, LMR 000.
REQ-013 sd_CS SHALL be 0 whenever CKE=1; every cycle not listed below SHALL carry NOP.
REQ-014 Init SHALL proceed as follows: CKE=0 for INIT_WAIT_CYC clocks; then CKE=1 with 5 NOP; then PRE with A10=1; then TRP-1 NOP.
REQ-015 Init SHALL continue: LMR BA=01 A=0; then TMRD-1 NOP; then LMR BA=00 A={4'b0,0,0,CAS_CODE,0,BL_CODE}; then TMRD-1 NOP.
REQ-016 Init SHALL continue: PRE with A10=1; then TRP-1 NOP; then NUM_REFRESH times (AR then TRFC-1 NOP).
REQ-017 Init SHALL end with LMR BA=00 carrying the same A value, after which init_done rises the following cycle and the FSM enters IDLE.
REQ-018 FSM states SHALL be WAIT, INIT_NOP, INIT_PRE, EMR, MR, PRE2, INIT_AR, MR2, IDLE, ACT, RW, RECOV and REF; each timed state waits on one shared down-counter.
REQ-019 req_ready SHALL equal (state==IDLE && !ref_pending && init_done), decoded combinationally.
REQ-020 On accept, the block SHALL issue ACT (BA=req_bank, A=req_row) on the next cycle, then TRCD-1 NOP.
REQ-021 After the ACT delay, the block SHALL issue READ or WRITE per the latched req_write, with A={2'b0,A10=1,req_col}, BA latched; it then issues TRECOV NOP and returns to IDLE.
REQ-022 Request fields SHALL be latched on accept; later changes to inputs SHALL NOT affect the transaction in flight.
REQ-023 The refresh timer SHALL count TREFI clocks from init_done rising, reload on expiry, and set ref_pending on expiry.
REQ-024 In IDLE with ref_pending set, the block SHALL issue AR, clear ref_pending, issue TRFC-1 NOP, then return to IDLE.
REQ-025 If expiry coincides with req_valid in IDLE, refresh SHALL win: req_ready is low that cycle.
REQ-026 An expiry during ACT/RW/RECOV SHALL be held pending until IDLE; a second expiry while pending SHALL leave a single pending refresh.
REQ-027 req_valid before init_done SHALL be ignored (req_ready=0).

Reset
REQ-028 On rst: state=WAIT, counter=INIT_WAIT_CYC, sd_CKE=0, sd_CS=1, command NOP, sd_A=0, sd_BA=0, req_ready=0, init_done=0, ref_pending=0, refresh timer=TREFI.
REQ-029 rst asserted mid-sequence or mid-transaction SHALL abort it and restart the full init on release.

Configuration
REQ-030 With DDR_AUTO_REFRESH_EN defined, REQ-023..026 SHALL apply; without it, there is no refresh timer, ref_pending is tied 0, and no AR is issued after init.

Structure
REQ-031 Package ddr_pkg SHALL hold the command encodings, the FSM state enum, and the EMR/MR field constants.
REQ-032 Sub-module ddr_refresh_timer (count, reload, pending flag) SHALL be instantiated only under DDR_AUTO_REFRESH_EN.

Verification
REQ-033 INIT_WAIT_CYC=10: CKE=0 for 10 clocks; then 5 NOP, PRE A10=1, 2 NOP, LMR BA=01 A=0, NOP, LMR A=13'b0000_0_0_010_0_001.
REQ-034 NUM_REFRESH=2, TRFC=11: init issues exactly 2 AR, each followed by 10 NOP, then LMR, then init_done=1.
REQ-035 Write request bank=2, row=0x1ABC, col=0x155: ACT BA=2 A=0x1ABC; 2 NOP; WRITE A=0x0555; 6 NOP; req_ready high again.
REQ-036 TREFI=50, with req_valid held high: AR appears within one transaction length of each expiry and is never interleaved between ACT and RW.
REQ-037 Expiry coincident with req_valid in IDLE: AR issued first, then ACT after TRFC clocks.
REQ-038 rst pulsed during RECOV: CKE=0 next cycle, init_done=0, and the full init sequence repeats.
